// File: rtl/pong_score_fsm.sv
// Pong game-flow controller: serve timing, scoring, game-over blink, and a
// two-digit seven-segment score layer rendered combinationally from pixel coordinates.
module pong_score_fsm #(
   parameter int SCREEN_WIDTH  = 640,
   parameter int SCREEN_HEIGHT = 480,
   parameter int WIN_SCORE     = 9,
   parameter int SERVE_FRAMES  = 60,
   parameter int BLINK_FRAMES  = 16
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_frame_tick,
   input  logic       i_miss_left,
   input  logic       i_miss_right,
   input  logic       i_start,
   input  logic [9:0] i_pixel_x,
   input  logic [9:0] i_pixel_y,
   input  logic       i_visible_area,
   output logic       o_ball_hold,
   output logic       o_serve_dir,
   output logic [3:0] o_score1,
   output logic [3:0] o_score2,
   output logic       o_game_over,
   output logic       o_winner,
   output logic       o_r,
   output logic       o_g,
   output logic       o_b
);

   typedef enum logic [1:0] {
      IDLE,
      SERVE,
      PLAY,
      GAME_OVER
   } state_t;

   localparam logic [3:0] WIN_VAL    = 4'(WIN_SCORE);
   localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES);
   localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

   localparam logic [9:0] D1_X  = 10'd280;
   localparam logic [9:0] D2_X  = 10'd336;
   localparam logic [9:0] DIG_Y = 10'd16;
   localparam logic [9:0] BOX_W = 10'd24;
   localparam logic [9:0] BOX_H = 10'd40;

   state_t     state_q, state_d;
   logic [3:0] score1_q, score1_d;
   logic [3:0] score2_q, score2_d;
   logic       serve_dir_q, serve_dir_d;
   logic       winner_q, winner_d;
   logic [7:0] count_q, count_d;
   logic       blink_q, blink_d;
   logic       hold_q;
   logic       game_over_q;

   // The frame counter is shared: serve countdown in SERVE, blink timer in GAME_OVER.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= IDLE;
         score1_q    <= '0;
         score2_q    <= '0;
         serve_dir_q <= 1'b0;
         winner_q    <= 1'b0;
         count_q     <= '0;
         blink_q     <= 1'b1;
         hold_q      <= 1'b1;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         score1_q    <= score1_d;
         score2_q    <= score2_d;
         serve_dir_q <= serve_dir_d;
         winner_q    <= winner_d;
         count_q     <= count_d;
         blink_q     <= blink_d;
         hold_q      <= (state_d != PLAY);
         game_over_q <= (state_d == GAME_OVER);
      end
   end

   // NOTE: every variable gets a default before the case so no path leaves
   // one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d     = state_q;
      score1_d    = score1_q;
      score2_d    = score2_q;
      serve_dir_d = serve_dir_q;
      winner_d    = winner_q;
      count_d     = count_q;
      blink_d     = blink_q;

      case (state_q)
         IDLE: begin
            if (i_start) begin
               state_d     = SERVE;
               count_d     = SERVE_LOAD;
               serve_dir_d = 1'b0;
            end
         end

         SERVE: begin
            if (i_frame_tick) begin
               if (count_q == 8'd1) begin
                  state_d = PLAY;
                  count_d = '0;
               end else begin
                  count_d = count_q - 8'd1;
               end
            end
         end

         PLAY: begin
            if (i_miss_left && i_miss_right) begin
               // Simultaneous misses void the rally: replay without scoring.
               state_d = SERVE;
               count_d = SERVE_LOAD;
            end else if (i_miss_right) begin
               score1_d    = score1_q + 4'd1;
               serve_dir_d = 1'b1;
               if (score1_d == WIN_VAL) begin
                  state_d  = GAME_OVER;
                  winner_d = 1'b0;
                  count_d  = '0;
                  blink_d  = 1'b1;
               end else begin
                  state_d = SERVE;
                  count_d = SERVE_LOAD;
               end
            end else if (i_miss_left) begin
               score2_d    = score2_q + 4'd1;
               serve_dir_d = 1'b0;
               if (score2_d == WIN_VAL) begin
                  state_d  = GAME_OVER;
                  winner_d = 1'b1;
                  count_d  = '0;
                  blink_d  = 1'b1;
               end else begin
                  state_d = SERVE;
                  count_d = SERVE_LOAD;
               end
            end
         end

         GAME_OVER: begin
            if (i_start) begin
               state_d     = SERVE;
               score1_d    = '0;
               score2_d    = '0;
               serve_dir_d = 1'b0;
               count_d     = SERVE_LOAD;
               blink_d     = 1'b1;
            end else if (i_frame_tick) begin
               if (count_q == BLINK_LAST) begin
                  count_d = '0;
                  blink_d = ~blink_q;
               end else begin
                  count_d = count_q + 8'd1;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign o_ball_hold = hold_q;
   assign o_serve_dir = serve_dir_q;
   assign o_score1    = score1_q;
   assign o_score2    = score2_q;
   assign o_game_over = game_over_q;
   assign o_winner    = winner_q;

   // Segment mask ordered {a,b,c,d,e,f,g}; out-of-range values stay blank.
   function automatic logic [6:0] seg_decode(input logic [3:0] value);
      logic [6:0] segs;
      case (value)
         4'd0:    segs = 7'b1111110;
         4'd1:    segs = 7'b0110000;
         4'd2:    segs = 7'b1101101;
         4'd3:    segs = 7'b1111001;
         4'd4:    segs = 7'b0110011;
         4'd5:    segs = 7'b1011011;
         4'd6:    segs = 7'b1011111;
         4'd7:    segs = 7'b1110000;
         4'd8:    segs = 7'b1111111;
         4'd9:    segs = 7'b1111011;
         default: segs = 7'b0000000;
      endcase
      return segs;
   endfunction

   // Caller guarantees dx < 24 and dy < 40.
   function automatic logic seg_hit(input logic [6:0] segs,
                                    input logic [4:0] dx,
                                    input logic [5:0] dy);
      logic left_col, right_col, upper, lower;
      left_col  = (dx <= 5'd3);
      right_col = (dx >= 5'd20);
      upper     = (dy <= 6'd19);
      lower     = (dy >= 6'd20);
      return (segs[6] && (dy <= 6'd3))
          || (segs[5] && right_col && upper)
          || (segs[4] && right_col && lower)
          || (segs[3] && (dy >= 6'd36))
          || (segs[2] && left_col && lower)
          || (segs[1] && left_col && upper)
          || (segs[0] && (dy >= 6'd18) && (dy <= 6'd21));
   endfunction

   logic [9:0] dx1, dx2, dy;
   logic       on_screen, in_row, in_box1, in_box2;
   logic       show1, show2, lit;

   always_comb begin
      dx1       = i_pixel_x - D1_X;
      dx2       = i_pixel_x - D2_X;
      dy        = i_pixel_y - DIG_Y;
      on_screen = i_visible_area
               && (i_pixel_x < 10'(SCREEN_WIDTH))
               && (i_pixel_y < 10'(SCREEN_HEIGHT));
      in_row    = (i_pixel_y >= DIG_Y) && (dy < BOX_H);
      in_box1   = in_row && (i_pixel_x >= D1_X) && (dx1 < BOX_W);
      in_box2   = in_row && (i_pixel_x >= D2_X) && (dx2 < BOX_W);
      // During the dark blink phase only the winner's digit disappears.
      show1     = !(game_over_q && !blink_q && !winner_q);
      show2     = !(game_over_q && !blink_q && winner_q);
      lit       = on_screen
               && ((in_box1 && show1 && seg_hit(seg_decode(score1_q), dx1[4:0], dy[5:0]))
                || (in_box2 && show2 && seg_hit(seg_decode(score2_q), dx2[4:0], dy[5:0])));
   end

   assign o_r = lit;
   assign o_g = lit;
   assign o_b = lit;

endmodule
